// File: rtl/trap_pkg.sv
// Shared state type and cause constants for the trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FLUSH
    } trap_state_e;

    localparam int IRQ_EXT   = 11;
    localparam int IRQ_SW    = 3;
    localparam int IRQ_TIMER = 7;
    localparam int RET_CAUSE = 0;

    // Interrupt causes carry their flag in the top bit of the cause word.
    function automatic int irq_flag_pos(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority pick of the pending trap source with its cause and save-PC.
module trap_prio_enc
    import trap_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic            i_ret_valid,
    input  logic            i_ext_irq,
    input  logic            i_sw_irq,
    input  logic            i_timer_irq,
    input  logic [XLEN-1:0] i_next_pc,
    input  logic            i_ie,
    output logic            o_req,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_save_pc
);

    localparam logic [XLEN-1:0] IRQ_FLAG =
        XLEN'(1) << irq_flag_pos(XLEN);

    always_comb begin
        o_req     = 1'b0;
        o_cause   = '0;
        o_save_pc = '0;
        priority case (1'b1)
            i_exc_valid: begin
                o_req     = 1'b1;
                o_cause   = XLEN'(i_exc_code);
                o_save_pc = i_exc_pc;
            end
            i_ret_valid: begin
                o_req     = 1'b1;
                o_cause   = XLEN'(RET_CAUSE);
            end
            (i_ie & i_ext_irq): begin
                o_req     = 1'b1;
                o_cause   = IRQ_FLAG | XLEN'(IRQ_EXT);
                o_save_pc = i_next_pc;
            end
            (i_ie & i_sw_irq): begin
                o_req     = 1'b1;
                o_cause   = IRQ_FLAG | XLEN'(IRQ_SW);
                o_save_pc = i_next_pc;
            end
            (i_ie & i_timer_irq): begin
                o_req     = 1'b1;
                o_cause   = IRQ_FLAG | XLEN'(IRQ_TIMER);
                o_save_pc = i_next_pc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/trap_controller.sv
// Context-switch initiator: picks a trap source, requests the CSR file,
// waits a bounded time for its acknowledge and stalls/flushes around it.
module trap_controller
    import trap_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2,
    parameter int XLEN        = 64
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            EXC_VALID,
    input  logic [3:0]      EXC_CODE,
    input  logic [XLEN-1:0] EXC_PC,
    input  logic            RET_VALID,
    input  logic            EXT_IRQ,
    input  logic            SW_IRQ,
    input  logic            TIMER_IRQ,
    input  logic [XLEN-1:0] NEXT_PC,
    input  logic            IE,
    input  logic            DE_CS,
    output logic            CS,
    output logic [XLEN-1:0] CAUSE,
    output logic [XLEN-1:0] SAVE_PC,
    output logic            STALL,
    output logic            FLUSH,
    output logic            TRAP_TAKEN,
    output logic            DROPPED
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW:0] TO = (CW + 1)'(ACK_TIMEOUT);

    trap_state_e     r_state;
    trap_state_e     w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [CW:0]     w_cnt_inc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_save_pc;
    logic            r_stall;
    logic            w_req;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_save_pc;
    logic            w_latch;
    logic            w_cs;
    logic            w_taken;
    logic            w_dropped;
    logic            w_flush;

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .i_exc_valid (EXC_VALID),
        .i_exc_code  (EXC_CODE),
        .i_exc_pc    (EXC_PC),
        .i_ret_valid (RET_VALID),
        .i_ext_irq   (EXT_IRQ),
        .i_sw_irq    (SW_IRQ),
        .i_timer_irq (TIMER_IRQ),
        .i_next_pc   (NEXT_PC),
        .i_ie        (IE),
        .o_req       (w_req),
        .o_cause     (w_cause),
        .o_save_pc   (w_save_pc)
    );

    assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        w_cs       = 1'b0;
        w_taken    = 1'b0;
        w_dropped  = 1'b0;
        w_flush    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_latch = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cs       = 1'b1;
                w_cnt_next = '0;
                w_next     = ST_WAIT;
            end
            ST_WAIT: begin
                if (DE_CS) begin
                    w_taken    = 1'b1;
                    w_cnt_next = '0;
                    w_next     = ST_FLUSH;
                end else if (w_cnt_inc == TO) begin
                    w_dropped  = 1'b1;
                    w_cnt_next = '0;
                    w_next     = ST_IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc[CW-1:0];
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cause   <= '0;
            r_save_pc <= '0;
            r_stall   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_stall <= (w_next != ST_IDLE);
            if (w_latch) begin
                r_cause   <= w_cause;
                r_save_pc <= w_save_pc;
            end
        end
    end

    // Reset masks the pulses in the same cycle so a late ack cannot leak out.
    assign CS         = w_cs & ~RESET;
    assign TRAP_TAKEN = w_taken & ~RESET;
    assign DROPPED    = w_dropped & ~RESET;
    assign FLUSH      = w_flush & ~RESET;
    assign STALL      = r_stall;
    assign CAUSE      = r_cause;
    assign SAVE_PC    = r_save_pc;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: vector table, corner sequences and a
// randomized run against a timeline model of the trap handshake.
module tb_trap_controller;

    localparam int XLEN = 64;
    localparam int TO   = 2;
    localparam logic [63:0] IRQB = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [63:0] exc_pc;
    logic        ret_valid;
    logic        ext_irq;
    logic        sw_irq;
    logic        timer_irq;
    logic [63:0] next_pc;
    logic        ie;
    logic        de_cs;
    logic        cs;
    logic [63:0] cause;
    logic [63:0] save_pc;
    logic        stall;
    logic        flush;
    logic        taken;
    logic        dropped;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_cause = '0;
    logic [63:0] m_pc = '0;

    always #5 clk = ~clk;

    trap_controller #(.ACK_TIMEOUT(TO), .XLEN(XLEN)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .EXC_VALID  (exc_valid),
        .EXC_CODE   (exc_code),
        .EXC_PC     (exc_pc),
        .RET_VALID  (ret_valid),
        .EXT_IRQ    (ext_irq),
        .SW_IRQ     (sw_irq),
        .TIMER_IRQ  (timer_irq),
        .NEXT_PC    (next_pc),
        .IE         (ie),
        .DE_CS      (de_cs),
        .CS         (cs),
        .CAUSE      (cause),
        .SAVE_PC    (save_pc),
        .STALL      (stall),
        .FLUSH      (flush),
        .TRAP_TAKEN (taken),
        .DROPPED    (dropped)
    );

    typedef struct {
        logic        exc;
        logic [3:0]  code;
        logic [63:0] epc;
        logic        ret;
        logic        ext;
        logic        sw;
        logic        tim;
        logic        ie;
        logic [63:0] npc;
        logic        req;
        logic [63:0] cause;
        logic [63:0] spc;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        exc_valid = 0; exc_code = 0; exc_pc = 0; ret_valid = 0;
        ext_irq = 0; sw_irq = 0; timer_irq = 0; next_pc = 0;
        ie = 0; de_cs = 0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_cs"}, 64'(cs), 0);
        chk({nm, "_flush"}, 64'(flush), 0);
        chk({nm, "_taken"}, 64'(taken), 0);
        chk({nm, "_dropped"}, 64'(dropped), 0);
        chk({nm, "_stall"}, 64'(stall), 0);
    endtask

    // One table vector: request in IDLE, ack two cycles after sampling.
    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        exc_valid = v.exc; exc_code = v.code; exc_pc = v.epc;
        ret_valid = v.ret; ext_irq = v.ext; sw_irq = v.sw;
        timer_irq = v.tim; ie = v.ie; next_pc = v.npc;
        @(negedge clk);
        chk({nm, "_idle_cs"}, 64'(cs), 0);
        chk({nm, "_idle_stall"}, 64'(stall), 0);
        tick();
        clr_inputs();
        @(negedge clk);
        if (v.req) begin
            m_cause = v.cause;
            m_pc = v.spc;
        end
        chk({nm, "_cs"}, 64'(cs), 64'(v.req));
        chk({nm, "_cause"}, cause, m_cause);
        chk({nm, "_save_pc"}, save_pc, m_pc);
        chk({nm, "_stall1"}, 64'(stall), 64'(v.req));
        tick();
        de_cs = 1;
        @(negedge clk);
        chk({nm, "_taken"}, 64'(taken), 64'(v.req));
        tick();
        de_cs = 0;
        @(negedge clk);
        chk({nm, "_flush"}, 64'(flush), 64'(v.req));
        chk({nm, "_stall3"}, 64'(stall), 64'(v.req));
        tick();
    endtask

    // Handshake for a request already driven at the start of an IDLE cycle.
    task automatic hs(input string nm, input logic [63:0] c,
                      input logic [63:0] p, input bit ack,
                      input bit clr_e, input bit clr_r);
        @(negedge clk);
        chk({nm, "_idle_cs"}, 64'(cs), 0);
        chk({nm, "_idle_stall"}, 64'(stall), 0);
        tick();
        @(negedge clk);
        chk({nm, "_cs"}, 64'(cs), 1);
        chk({nm, "_cause"}, cause, c);
        chk({nm, "_save_pc"}, save_pc, p);
        chk({nm, "_stall"}, 64'(stall), 1);
        m_cause = c;
        m_pc = p;
        tick();
        de_cs = ack;
        if (ack) begin
            @(negedge clk);
            chk({nm, "_taken"}, 64'(taken), 1);
            tick();
            de_cs = 0;
            if (clr_e) exc_valid = 0;
            if (clr_r) ret_valid = 0;
            @(negedge clk);
            chk({nm, "_flush"}, 64'(flush), 1);
            chk({nm, "_stall_f"}, 64'(stall), 1);
            tick();
        end else begin
            for (int k = 2; k <= 1 + TO; k++) begin
                @(negedge clk);
                chk({nm, "_dropped"}, 64'(dropped), 64'(k == 1 + TO));
                chk({nm, "_notaken"}, 64'(taken), 0);
                chk({nm, "_stall_w"}, 64'(stall), 1);
                tick();
            end
            if (clr_e) exc_valid = 0;
            if (clr_r) ret_valid = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        m_cause = '0;
        m_pc = '0;
    endtask

    // Timeline reference model state for the random run.
    bit          busy;
    int          t_acc;
    int          t_ack;
    int          src;
    bit          clr_e;
    bit          clr_r;

    initial begin
        bit          e_cs, e_tk, e_dr, e_fl, e_st, done;
        logic [63:0] pc_c, pc_p;

        clr_inputs();
        rst = 1;
        vt[0] = '{1, 4'd2, 64'h80, 0, 0, 0, 0, 1, 64'h0,
                  1, 64'h2, 64'h80};
        vt[1] = '{0, 4'd0, 64'h0, 0, 0, 0, 1, 1, 64'h100,
                  1, IRQB | 64'd7, 64'h100};
        vt[2] = '{0, 4'd0, 64'h0, 0, 0, 0, 1, 0, 64'h140,
                  0, 64'h0, 64'h0};
        vt[3] = '{0, 4'd0, 64'h0, 0, 1, 1, 1, 1, 64'h1000,
                  1, IRQB | 64'd11, 64'h1000};
        vt[4] = '{0, 4'd0, 64'h0, 0, 0, 1, 1, 1, 64'h2004,
                  1, IRQB | 64'd3, 64'h2004};
        vt[5] = '{0, 4'd0, 64'h0, 1, 1, 0, 0, 1, 64'h3000,
                  1, 64'h0, 64'h0};
        vt[6] = '{1, 4'hf, 64'hdead_beef_0000_0010, 0, 1, 1, 1, 0,
                  64'h44, 1, 64'hf, 64'hdead_beef_0000_0010};
        vt[7] = '{0, 4'd0, 64'h0, 1, 0, 0, 0, 0, 64'h55,
                  1, 64'h0, 64'h0};

        tick();
        @(negedge clk);
        chk_quiet("rst_hold");
        tick();
        rst = 0;
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_cause", cause, 0);
        chk("rst_save_pc", save_pc, 0);
        tick();

        foreach (vt[i]) run_vec(i, vt[i]);

        // Three simultaneous sources retire in priority order, 4 cycles apart.
        exc_valid = 1; exc_code = 4'd5; exc_pc = 64'h200;
        ret_valid = 1; ext_irq = 1; ie = 1; next_pc = 64'h300;
        hs("sim_exc", 64'h5, 64'h200, 1, 1, 0);
        hs("sim_ret", 64'h0, 64'h0, 1, 0, 1);
        hs("sim_ext", IRQB | 64'd11, 64'h300, 1, 0, 0);
        clr_inputs();

        // Unacknowledged xRET times out.
        ret_valid = 1;
        hs("drop_ret", 64'h0, 64'h0, 0, 0, 1);
        @(negedge clk);
        chk("drop_stall_after", 64'(stall), 0);
        chk("drop_cs_after", 64'(cs), 0);
        tick();

        // Reset while waiting for the ack; the late ack must be ignored.
        exc_valid = 1; exc_code = 4'd9; exc_pc = 64'h440;
        tick();
        @(negedge clk);
        chk("rw_cs", 64'(cs), 1);
        tick();
        rst = 1;
        exc_valid = 0;
        @(negedge clk);
        chk("rw_taken_in_rst", 64'(taken), 0);
        tick();
        rst = 0;
        de_cs = 1;
        @(negedge clk);
        chk_quiet("rw_after");
        chk("rw_cause", cause, 0);
        chk("rw_save_pc", save_pc, 0);
        tick();
        de_cs = 0;
        @(negedge clk);
        chk("rw_flush_late", 64'(flush), 0);
        chk("rw_stall_late", 64'(stall), 0);
        tick();

        // Masked timer interrupt never issues.
        timer_irq = 1; ie = 0; next_pc = 64'h100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("ie0_cs%0d", k), 64'(cs), 0);
            tick();
        end
        clr_inputs();

        // Randomized run against the timeline model.
        do_reset();
        busy = 0; t_acc = 0; t_ack = -1; src = 0; clr_e = 0; clr_r = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (clr_e) exc_valid = 0;
            if (clr_r) ret_valid = 0;
            clr_e = 0;
            clr_r = 0;
            if (!exc_valid && $urandom_range(7) == 0) begin
                exc_valid = 1;
                exc_code = 4'($urandom);
                exc_pc = {$urandom, $urandom};
            end
            if (!ret_valid && $urandom_range(7) == 0) ret_valid = 1;
            if ($urandom_range(9) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(9) == 0) sw_irq = ~sw_irq;
            if ($urandom_range(9) == 0) timer_irq = ~timer_irq;
            ie = ($urandom_range(3) != 0);
            next_pc = {$urandom, $urandom};
            de_cs = 1'($urandom_range(1));
            @(negedge clk);

            e_cs = 0; e_tk = 0; e_dr = 0; e_fl = 0; done = 0;
            e_st = busy;
            if (busy) begin
                if (cyc == t_acc + 1) e_cs = 1;
                else if (t_ack < 0) begin
                    if (de_cs) begin
                        e_tk = 1;
                        t_ack = cyc;
                    end else if (cyc == t_acc + 1 + TO) begin
                        e_dr = 1;
                        done = 1;
                    end
                end else if (cyc == t_ack + 1) begin
                    e_fl = 1;
                    done = 1;
                end
            end
            chk("rnd_cs", 64'(cs), 64'(e_cs));
            chk("rnd_taken", 64'(taken), 64'(e_tk));
            chk("rnd_dropped", 64'(dropped), 64'(e_dr));
            chk("rnd_flush", 64'(flush), 64'(e_fl));
            chk("rnd_stall", 64'(stall), 64'(e_st));
            chk("rnd_cause", cause, m_cause);
            chk("rnd_save_pc", save_pc, m_pc);

            if ((e_tk || e_dr) && src == 0) clr_e = 1;
            if ((e_tk || e_dr) && src == 1) clr_r = 1;
            if (done) begin
                busy = 0;
            end else if (!busy) begin
                src = -1;
                pc_c = '0;
                pc_p = '0;
                if (exc_valid) begin
                    src = 0;
                    pc_c = 64'(exc_code);
                    pc_p = exc_pc;
                end else if (ret_valid) begin
                    src = 1;
                end else if (ie && (ext_irq || sw_irq || timer_irq)) begin
                    src = 2;
                    pc_c = IRQB + (ext_irq ? 64'd11 : sw_irq ? 64'd3 : 64'd7);
                    pc_p = next_pc;
                end
                if (src >= 0) begin
                    busy = 1;
                    t_acc = cyc;
                    t_ack = -1;
                    m_cause = pc_c;
                    m_pc = pc_p;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Initiator side of the core's context-switch interface. Collects the synchronous exception from execute, xRET requests from decode, and the three machine interrupt lines. Prioritises them and drives the single-cycle `CS`/`CAUSE`/`SAVE_PC` request into the CSR file. It then waits for the CSR file's `DE_CS` acknowledge and stalls and flushes the pipeline around the redirect.

## Interface
Parameters:
- `ACK_TIMEOUT`, 2: cycles after the `CS` pulse during which `DE_CS` is sampled before the request is dropped.
- `XLEN`, 64: width of `CAUSE`, PCs and internal cause register.

Ports (clock and reset first; one clock, reset synchronous active-high):
- `CLK` in 1: core clock.
- `RESET` in 1: synchronous, active-high.
- `EXC_VALID` in 1: execute-stage instruction raised an exception; held until `TRAP_TAKEN` or `DROPPED`.
- `EXC_CODE` in 4: exception cause code.
- `EXC_PC` in XLEN: PC of the faulting instruction.
- `RET_VALID` in 1: decode holds an xRET; held like `EXC_VALID`.
- `EXT_IRQ`, `SW_IRQ`, `TIMER_IRQ` in 1 each: level interrupt lines.
- `NEXT_PC` in XLEN: PC of the oldest unretired instruction, used as the return point for interrupts.
- `IE` in 1: CSR-file global interrupt enable for the current privilege.
- `DE_CS` in 1: CSR-file acknowledge; PC redirect is valid this cycle.
- `CS` out 1: context-switch request to the CSR file.
- `CAUSE` out XLEN: cause value.
- `SAVE_PC` out XLEN: value for mepc.
- `STALL` out 1: freeze fetch/decode/execute.
- `FLUSH` out 1: one-cycle pipeline kill.
- `TRAP_TAKEN` out 1: one-cycle pulse, request accepted.
- `DROPPED` out 1: one-cycle pulse, request not acknowledged.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `FLUSH`.
- Priority in `IDLE`, highest first: `EXC_VALID` > `RET_VALID` > `EXT_IRQ` > `SW_IRQ` > `TIMER_IRQ`.
  - Interrupts are eligible only when `IE`=1.
  - Exceptions and RET are eligible regardless of `IE`.
- Cause encoding:
  - Exception: `{1'b0, zero-extended EXC_CODE}`.
  - RET: `0`.
  - Interrupts: bit XLEN-1 set, low bits `11` (ext), `3` (sw), `7` (timer).
- `SAVE_PC` by source:
  - Exception: `EXC_PC`.
  - Interrupt: `NEXT_PC`.
  - RET: `0`. mepc is not written on RET.
- `IDLE` with an eligible request: latch cause and save-PC, go to `ISSUE`.
- `ISSUE`: `CS`=1 for exactly this cycle with the latched values, then go to `WAIT` with the timeout counter at 0.
- `WAIT`:
  - `DE_CS`=1 → go to `FLUSH` and pulse `TRAP_TAKEN`.
  - Otherwise the counter increments. When it reaches `ACK_TIMEOUT` → go to `IDLE` and pulse `DROPPED`.
- `FLUSH`: `FLUSH`=1 for one cycle, then go to `IDLE`.
- `CAUSE`/`SAVE_PC` hold their latched values from `ISSUE` until the next latch; they are 0 after reset.
- Inputs arriving while not in `IDLE` are ignored. Exception and RET sources hold until `TRAP_TAKEN`/`DROPPED`; interrupts are level lines and are re-evaluated in `IDLE`.
- Simultaneous requests: only the highest-priority one is latched; the others are re-evaluated next `IDLE` cycle.
- `DE_CS` seen outside `WAIT` is ignored.

## Timing
- Reset values: all outputs 0, state `IDLE`, counter 0. `RESET` in any state returns to `IDLE` on the next edge with no `CS`, `FLUSH` or pulses.
- Request sampled in `IDLE` at cycle N:
  - `CS` at N+1.
  - `DE_CS` sampled from N+2.
  - With acknowledge at N+2: `TRAP_TAKEN` at N+2, `FLUSH` at N+3, `IDLE` at N+4.
- `STALL` is registered: high from N+1 through the `FLUSH` cycle inclusive, or through the `DROPPED` cycle.
- Minimum spacing between two `CS` pulses: 4 cycles.

## Structure
- Shared package `trap_pkg` holds:
  - State enum.
  - Interrupt cause codes (`IRQ_EXT=11`, `IRQ_SW=3`, `IRQ_TIMER=7`).
  - Interrupt flag bit position.
  - xRET cause constant `0`.
- One sub-module, `trap_prio_enc`: combinational selection of request, cause and save-PC from the inputs and `IE`.

## Test plan
- `EXC_VALID`=1, `EXC_CODE`=2, `EXC_PC`=0x80 at N; `DE_CS`=1 at N+2 → `CS` at N+1 with `CAUSE`=2, `SAVE_PC`=0x80; `TRAP_TAKEN` N+2; `FLUSH` N+3; `STALL` N+1..N+3.
- `TIMER_IRQ`=1, `IE`=1, `NEXT_PC`=0x100 → `CAUSE`=0x8000_0000_0000_0007, `SAVE_PC`=0x100. With `IE`=0 → no `CS` for 10 cycles.
- `EXC_VALID`, `RET_VALID` and `EXT_IRQ` asserted together → first `CS` carries the exception cause; RET issues after the exception is retired; `EXT_IRQ` is taken after that if still asserted with `IE`=1.
- `RET_VALID`=1 with `DE_CS` never asserted → `CS` at N+1, `DROPPED` at N+1+`ACK_TIMEOUT`, `STALL` low the cycle after.
- `RESET` asserted in `WAIT` → next cycle all outputs 0 and state `IDLE`; a late `DE_CS` produces no `FLUSH`.
